// File: rtl/writeback_stage_if.sv
// Writeback stage bundle: pipeline result, MDU offer/accept, regfile write.
// slave = writeback stage side, master = surrounding core side.
interface writeback_stage_if;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_result;
  logic        pipe_is_load;
  logic [2:0]  pipe_funct3;
  logic [1:0]  pipe_addr_lo;
  logic [31:0] pipe_load_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_result;
  logic        mdu_ready;
  logic        wb_stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_result,
    input  pipe_is_load, pipe_funct3,
    input  pipe_addr_lo, pipe_load_data,
    input  mdu_valid, mdu_rd, mdu_result,
    output mdu_ready, wb_stall,
    output wb_en, wb_rd, wb_data
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_result,
    output pipe_is_load, pipe_funct3,
    output pipe_addr_lo, pipe_load_data,
    output mdu_valid, mdu_rd, mdu_result,
    input  mdu_ready, wb_stall,
    input  wb_en, wb_rd, wb_data
  );
endinterface

// File: rtl/writeback_stage.sv
// RV32 writeback: merges pipeline and MDU results onto the regfile port.
// Define WB_MDU_EN to build the MDU arbitration and starvation guard.
module writeback_stage #(
  parameter int STARVE_LIMIT = 3
) (
  input logic            clk,
  input logic            rst_n,
  writeback_stage_if.slave bus
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic        pipe_take;
  logic        mdu_take;
  logic        stall;
  logic        mdu_rdy;

  logic        en_q,   en_d;
  logic [4:0]  rd_q,   rd_d;
  logic [31:0] data_q, data_d;

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic [2:0]  f3;

`ifdef WB_MDU_EN
  logic [3:0] cnt_q, cnt_d;

  assign stall     = bus.mdu_valid && (cnt_q >= LIM);
  assign pipe_take = bus.pipe_valid && !stall;
  assign mdu_rdy   = rst_n && !pipe_take;
  assign mdu_take  = bus.mdu_valid && mdu_rdy;

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.mdu_valid || mdu_take)
      cnt_d = '0;
    else if (cnt_q != 4'hf)
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  logic unused_mdu;

  assign unused_mdu = ^{bus.mdu_valid, bus.mdu_rd,
                        bus.mdu_result, LIM};
  assign stall     = 1'b0;
  assign pipe_take = bus.pipe_valid;
  assign mdu_rdy   = 1'b0;
  assign mdu_take  = 1'b0;
`endif

  assign f3     = bus.pipe_funct3;
  assign byte_v = bus.pipe_load_data[{bus.pipe_addr_lo, 3'b000} +: 8];
  assign half_v = bus.pipe_load_data[{bus.pipe_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_ext = bus.pipe_load_data;
    unique case (1'b1)
      f3 == 3'b000: ld_ext = {{24{byte_v[7]}}, byte_v};
      f3 == 3'b001: ld_ext = {{16{half_v[15]}}, half_v};
      f3 == 3'b100: ld_ext = {24'h0, byte_v};
      f3 == 3'b101: ld_ext = {16'h0, half_v};
      default:      ld_ext = bus.pipe_load_data;
    endcase
  end

  // x0 writes still consume the source but never raise the write enable
  always_comb begin
    en_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (pipe_take) begin
      en_d   = |bus.pipe_rd;
      rd_d   = bus.pipe_rd;
      data_d = bus.pipe_is_load ? ld_ext : bus.pipe_result;
    end else if (mdu_take) begin
      en_d   = |bus.mdu_rd;
      rd_d   = bus.mdu_rd;
      data_d = bus.mdu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign bus.mdu_ready = mdu_rdy;
  assign bus.wb_stall  = stall;
  assign bus.wb_en     = en_q;
  assign bus.wb_rd     = rd_q;
  assign bus.wb_data   = data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: driver + reference model push
// per-cycle expectations, a negedge monitor pops and compares.
module tb_writeback_stage;

  localparam int LIMIT = 3;
`ifdef WB_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    logic        ld;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] data;
  } ptx_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
  } mtx_t;

  typedef struct {
    logic        ready;
    logic        stall;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  writeback_stage_if bus ();

  writeback_stage #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ptx_t pq[$];
  mtx_t mq[$];
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  bit pipe_on = 1'b0;
  bit mdu_on = 1'b0;
  bit pipe_hold = 1'b0;
  bit mdu_hold = 1'b0;
  int wait_cyc = 0;
  logic        cur_en = 1'b0;
  logic [4:0]  cur_rd = '0;
  logic [31:0] cur_data = '0;

  function automatic logic [31:0] ld_ref(
    input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mdu_ready", 32'(bus.mdu_ready), 32'(e.ready));
      chk("wb_stall", 32'(bus.wb_stall), 32'(e.stall));
      chk("wb_en", 32'(bus.wb_en), 32'(e.en));
      chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
      chk("wb_data", bus.wb_data, e.data);
    end
  end

  task automatic step(input bit rstn);
    bit pv, mv, stall, ready, pt, mt;
    exp_t e;
    ptx_t p;
    mtx_t m;
    @(posedge clk);
    #1;
    rst_n = rstn;
    pv = (pq.size() > 0) && (pipe_on || pipe_hold);
    mv = (mq.size() > 0) && (mdu_on || mdu_hold);
    bus.pipe_valid = pv;
    if (pv) begin
      p = pq[0];
      bus.pipe_rd = p.rd;
      bus.pipe_result = p.res;
      bus.pipe_is_load = p.ld;
      bus.pipe_funct3 = p.f3;
      bus.pipe_addr_lo = p.alo;
      bus.pipe_load_data = p.data;
    end else begin
      bus.pipe_rd = 5'($urandom);
      bus.pipe_result = $urandom;
      bus.pipe_is_load = 1'($urandom);
      bus.pipe_funct3 = 3'($urandom);
      bus.pipe_addr_lo = 2'($urandom);
      bus.pipe_load_data = $urandom;
    end
    bus.mdu_valid = mv;
    if (mv) begin
      bus.mdu_rd = mq[0].rd;
      bus.mdu_result = mq[0].res;
    end else begin
      bus.mdu_rd = 5'($urandom);
      bus.mdu_result = $urandom;
    end
    if (!rstn) begin
      e.ready = 1'b0;
      e.stall = 1'b0;
      e.en = 1'b0;
      e.rd = '0;
      e.data = '0;
      exp_q.push_back(e);
      wait_cyc = 0;
      cur_en = 1'b0;
      cur_rd = '0;
      cur_data = '0;
      pipe_hold = pv;
      mdu_hold = mv;
      return;
    end
    stall = MDU_EN && mv && (wait_cyc >= LIMIT);
    pt = pv && !stall;
    ready = MDU_EN && !pt;
    mt = mv && ready;
    e.ready = ready;
    e.stall = stall;
    e.en = cur_en;
    e.rd = cur_rd;
    e.data = cur_data;
    exp_q.push_back(e);
    if (mt || !mv) wait_cyc = 0;
    else if (wait_cyc < 15) wait_cyc++;
    if (pt) begin
      p = pq.pop_front();
      cur_en = (p.rd != 0);
      cur_rd = p.rd;
      cur_data = p.ld ? ld_ref(p.f3, p.alo, p.data) : p.res;
    end else if (mt) begin
      m = mq.pop_front();
      cur_en = (m.rd != 0);
      cur_rd = m.rd;
      cur_data = m.res;
    end else begin
      cur_en = 1'b0;
    end
    pipe_hold = pv && !pt;
    mdu_hold = mv && !mt;
  endtask

  function automatic ptx_t mkp(input logic [4:0] rd, input logic [31:0] res,
      input logic ld, input logic [2:0] f3, input logic [1:0] alo,
      input logic [31:0] data);
    ptx_t p;
    p.rd = rd; p.res = res; p.ld = ld;
    p.f3 = f3; p.alo = alo; p.data = data;
    return p;
  endfunction

  function automatic mtx_t mkm(input logic [4:0] rd, input logic [31:0] res);
    mtx_t m;
    m.rd = rd; m.res = res;
    return m;
  endfunction

  function automatic ptx_t rndp();
    return mkp(5'($urandom), $urandom, 1'($urandom), 3'($urandom),
               2'($urandom), $urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pipe_valid = 1'b0;
    bus.mdu_valid = 1'b0;
    step(1'b0);
    step(1'b0);

    pipe_on = 1'b1;
    pq.push_back(mkp(5, 0, 1, 3'b000, 3, 32'h80FF_1234));
    pq.push_back(mkp(6, 0, 1, 3'b101, 2, 32'h80FF_1234));
    pq.push_back(mkp(7, 0, 1, 3'b001, 2, 32'h80FF_1234));
    pq.push_back(mkp(8, 0, 1, 3'b010, 1, 32'h80FF_1234));
    pq.push_back(mkp(9, 0, 1, 3'b011, 2, 32'hC001_7E57));
    pq.push_back(mkp(0, 32'hDEAD_BEEF, 0, 3'b000, 0, 0));
    pq.push_back(mkp(2, 32'h1234_5678, 0, 3'b000, 0, 0));
    repeat (8) step(1'b1);

    pipe_on = 1'b0;
    mdu_on = 1'b1;
    mq.push_back(mkm(0, 32'hFACE_0000));
    repeat (2) step(1'b1);

    pipe_on = 1'b1;
    pq.push_back(mkp(3, 32'h3333_3333, 0, 0, 0, 0));
    mq.push_back(mkm(4, 32'h4444_4444));
    step(1'b1);
    pipe_on = 1'b0;
    repeat (2) step(1'b1);

    pipe_on = 1'b1;
    for (int i = 0; i < 6; i++)
      pq.push_back(mkp(5'(10 + i), 32'(i), 0, 0, 0, 0));
    mq.push_back(mkm(20, 32'h2020_2020));
    repeat (9) step(1'b1);

    pq.push_back(mkp(12, 32'h1212_1212, 0, 0, 0, 0));
    mq.push_back(mkm(11, 32'h1111_1111));
    step(1'b1);
    pipe_on = 1'b0;
    step(1'b0);
    repeat (3) step(1'b1);

    for (int i = 0; i < 2000; i++) begin
      if (pq.size() < 4 && $urandom_range(0, 2) != 0)
        pq.push_back(rndp());
      if (mq.size() < 3 && $urandom_range(0, 3) == 0)
        mq.push_back(mkm(5'($urandom), $urandom));
      pipe_on = ($urandom_range(0, 3) != 0);
      mdu_on = ($urandom_range(0, 1) != 0);
      step($urandom_range(0, 199) != 0);
    end

    pipe_on = 1'b0;
    mdu_on = 1'b0;
    repeat (4) step(1'b1);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
